// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the shared-multiplier scheduler.
package mult_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int OPW   = 4;
   localparam int PW    = 8;
   localparam int STATW = 16;

endpackage

// File: rtl/main.sv
// Combinational 4x4 unsigned multiplier producing a full 8-bit product.
module main (
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] o
);

   assign o = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   logic [IDW-1:0] cand;
   logic           found;

   // Walk the requesters starting at ptr; the first valid one wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDW'((int'(ptr) + i) % NREQ);
         if (en && !found && req[cand]) begin
            found       = 1'b1;
            gnt[cand]   = 1'b1;
            gnt_idx     = cand;
         end
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 4x4 multiplier among NREQ requesters.
// Define MULT_SCHED_STATS_EN to add per-requester saturating completion counters (stat_cnt).
module mult_share_sched
   import mult_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*4-1:0]  req_x,
   input  logic [NREQ*4-1:0]  req_y,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [7:0]         rsp_data,
   output logic [IDW-1:0]     rsp_id,
   input  logic               rsp_ready,
   output logic               busy
`ifdef MULT_SCHED_STATS_EN
   ,
   output logic [NREQ*16-1:0] stat_cnt
`endif
);

   state_t         state;
   state_t         state_next;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] ptr_next;
   logic [IDW-1:0] op_id;
   logic [IDW-1:0] gnt_idx;
   logic [NREQ-1:0] gnt;
   logic           accept_win;
   logic           accept;
   logic [OPW-1:0] op_x;
   logic [OPW-1:0] op_y;
   logic [OPW-1:0] sel_x;
   logic [OPW-1:0] sel_y;
   logic [PW-1:0]  prod;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .en      (accept_win),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   main u_mult (
      .x (op_x),
      .y (op_y),
      .o (prod)
   );

   assign accept    = |gnt;
   assign req_ready = gnt;
   assign busy      = (state != IDLE);
   assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

   // The window opens in IDLE, or in RESP on the cycle the response drains.
   always_comb begin
      state_next = state;
      accept_win = 1'b0;
      case (state)
         IDLE: begin
            accept_win = 1'b1;
            if (accept) state_next = CALC;
         end
         CALC: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               accept_win = 1'b1;
               state_next = accept ? CALC : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_x = req_x[i*OPW +: OPW];
            sel_y = req_y[i*OPW +: OPW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Operand capture on grant; product capture in CALC; drain on response handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         op_x      <= '0;
         op_y      <= '0;
         op_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else begin
         if (accept) begin
            op_x   <= sel_x;
            op_y   <= sel_y;
            op_id  <= gnt_idx;
            rr_ptr <= ptr_next;
         end
         if (state == CALC) begin
            rsp_data  <= prod;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef MULT_SCHED_STATS_EN
   logic rsp_hs;
   assign rsp_hs = rsp_valid & rsp_ready;

   for (genvar g = 0; g < NREQ; g++) begin : g_stat
      logic [STATW-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) cnt <= '0;
         else if (rsp_hs && rsp_id == IDW'(g) && cnt != '1) cnt <= cnt + 1'b1;
      end

      assign stat_cnt[g*STATW +: STATW] = cnt;
   end
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed self-checking bench for mult_share_sched (default NREQ=4 build, stats checks when MULT_SCHED_STATS_EN is defined).
module tb_mult_share_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*4-1:0] req_x;
   logic [NREQ*4-1:0] req_y;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [7:0]        rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_ready;
   logic              busy;
`ifdef MULT_SCHED_STATS_EN
   logic [NREQ*16-1:0] stat_cnt;
`endif

   int checks = 0;
   int errors = 0;

   mult_share_sched #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
`ifdef MULT_SCHED_STATS_EN
      ,
      .stat_cnt  (stat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int idx, input logic [3:0] x, input logic [3:0] y);
      req_x[idx*4 +: 4] = x;
      req_y[idx*4 +: 4] = y;
   endtask

   // One isolated operation from requester idx, starting in IDLE with rsp_ready high.
   task automatic do_op(input int idx, input logic [3:0] x, input logic [3:0] y,
                        input int exp_prod, input string tag);
      set_op(idx, x, y);
      req_valid = NREQ'(1 << idx);
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
      tick();
      req_valid = '0;
      chk({tag, "_calc_busy"}, 32'(busy), 1);
      tick();
      chk({tag, "_valid"}, 32'(rsp_valid), 1);
      chk({tag, "_data"}, 32'(rsp_data), 32'(exp_prod));
      chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
      tick();
      chk({tag, "_drained"}, 32'(rsp_valid), 0);
      chk({tag, "_idle"}, 32'(busy), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b0;
      #2;
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_data", 32'(rsp_data), 0);
      chk("rst_id", 32'(rsp_id), 0);
      #10;
      rst_n = 1'b1;
      tick();

      // Single op, held response until rsp_ready rises
      set_op(0, 4'd7, 4'd9);
      req_valid = 4'b0001;
      #1;
      chk("single_ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      chk("single_calc_valid", 32'(rsp_valid), 0);
      chk("single_calc_ready", 32'(req_ready), 0);
      tick();
      chk("single_valid", 32'(rsp_valid), 1);
      chk("single_data", 32'(rsp_data), 63);
      chk("single_id", 32'(rsp_id), 0);
      rsp_ready = 1'b1;
      tick();
      chk("single_drain", 32'(rsp_valid), 0);

      // Boundary operands; pointer walks 1,2,3
      do_op(1, 4'd15, 4'd15, 225, "max");
      do_op(2, 4'd0, 4'd13, 0, "zero");
      do_op(3, 4'd1, 4'd11, 11, "one");

      // Fairness: all valid, pointer back at 0
      for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 2), 4'd3);
      req_valid = 4'b1111;
      #1;
      chk("fair_first_ready", 32'(req_ready), 32'b0001);
      for (int i = 0; i < NREQ; i++) begin
         tick();
         chk("fair_calc_ready", 32'(req_ready), 0);
         tick();
         chk("fair_valid", 32'(rsp_valid), 1);
         chk("fair_id", 32'(rsp_id), 32'(i));
         chk("fair_data", 32'(rsp_data), 32'((i + 2) * 3));
         chk("fair_next_ready", 32'(req_ready), 32'(1 << ((i + 1) % NREQ)));
      end

      // Back-pressure: requester 0 re-accepted, then stall in RESP
      tick();
      rsp_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_data", 32'(rsp_data), 6);
         chk("bp_id", 32'(rsp_id), 0);
         chk("bp_ready", 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      chk("bp_release_drop", 32'(rsp_valid), 0);
      chk("bp_release_busy", 32'(busy), 1);
      tick();
      chk("bp_next_data", 32'(rsp_data), 9);
      chk("bp_next_id", 32'(rsp_id), 1);
      tick();
      chk("bp_idle", 32'(busy), 0);

      // Reset while requester 2 is in CALC
      set_op(2, 4'd5, 4'd5);
      req_valid = 4'b0100;
      #1;
      chk("rmid_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid_valid", 32'(rsp_valid), 0);
      chk("rmid_busy", 32'(busy), 0);
      chk("rmid_data", 32'(rsp_data), 0);
      #1;
      rst_n = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("rmid_first_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      tick();
      chk("rmid_data_after", 32'(rsp_data), 6);
      chk("rmid_id_after", 32'(rsp_id), 0);
      tick();
      chk("rmid_idle", 32'(busy), 0);

`ifdef MULT_SCHED_STATS_EN
      #2;
      rst_n = 1'b0;
      #1;
      chk("stat_rst", 32'(stat_cnt[31:0]), 0);
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         // Pointer must return to 2 each time, so cycle through the other requesters silently
         do_op(2, 4'd3, 4'd4, 12, "stat_op");
         do_op(3, 4'd1, 4'd1, 1, "stat_fill3");
         do_op(0, 4'd1, 4'd1, 1, "stat_fill0");
         do_op(1, 4'd1, 4'd1, 1, "stat_fill1");
      end
      chk("stat_req2", 32'(stat_cnt[47:32]), 3);
      chk("stat_req3", 32'(stat_cnt[63:48]), 3);
      chk("stat_req0", 32'(stat_cnt[15:0]), 3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
